// File: rtl/phy_tx_serializer_if.sv
// Lane-side handshake bundle for phy_tx_serializer: LANES words of WIDTH bits,
// each with its own valid/ready pair.
interface phy_tx_serializer_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic [LANES-1:0]       ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/phy_tx_serializer.sv
// Round-robin LANES-to-1 serializer, MSB first, with idle-symbol fill.
// Optional even-parity bit per slot when PHY_TX_PARITY_EN is defined.
module phy_tx_serializer #(
  parameter int              LANES      = 4,
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(8'hBC),
  parameter int              INIT_WORDS = 4,
  localparam int             LSEL_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk_32f,
  input  logic              reset,
  phy_tx_serializer_if.slave lanes,
  input  logic              inserter,
  output logic              data_out,
  output logic              IDLE_OUT,
  output logic [LSEL_W-1:0] lane_sel,
  output logic              frame_start
);

`ifdef PHY_TX_PARITY_EN
  localparam int SLOT = WIDTH + 1;
`else
  localparam int SLOT = WIDTH;
`endif
  localparam int CNT_W  = $clog2(SLOT);
  localparam int INIT_W = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SLOT - 1);
  localparam logic [LSEL_W-1:0] LAST_LANE = LSEL_W'(LANES - 1);
  localparam logic [INIT_W-1:0] LAST_INIT = INIT_W'((INIT_WORDS > 0) ? INIT_WORDS - 1 : 0);

  // The reset condition itself is the RESET state; release lands directly in
  // INIT, or in RUN when no init words are configured.
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t ST_AFTER_RESET = (INIT_WORDS == 0) ? ST_RUN : ST_INIT;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [INIT_W-1:0] init_cnt_reg;
  logic [LSEL_W-1:0] lane_idx_reg;
  logic [SLOT-1:0]   shift_reg;
  logic              idle_reg;
  logic              frame_reg;
  logic [LSEL_W-1:0] lane_sel_reg;

  logic              load;
  logic              serve;
  logic              xfer;
  logic [WIDTH-1:0]  lane_word [LANES];
  logic [WIDTH-1:0]  load_word;
  logic [SLOT-1:0]   load_frame;

  assign load = (bit_cnt_reg == LAST_BIT);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state_reg <= ST_AFTER_RESET;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && load && init_cnt_reg == LAST_INIT)
      state_next = ST_RUN;
  end

  always_comb begin
    serve = load && inserter && (state_reg == ST_RUN);
    xfer  = serve && lanes.valid_in[lane_idx_reg];
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_word[gi]       = lanes.data_in[gi*WIDTH +: WIDTH];
      assign lanes.ready_out[gi] = serve && (lane_idx_reg == LSEL_W'(gi));
    end
  endgenerate

  assign load_word = xfer ? lane_word[lane_idx_reg] : IDLE_SYM;
`ifdef PHY_TX_PARITY_EN
  assign load_frame = {load_word, ^load_word};
`else
  assign load_frame = load_word;
`endif

  // Counter is preset to the last bit so the first edge after release loads.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg  <= LAST_BIT;
      init_cnt_reg <= '0;
      lane_idx_reg <= '0;
    end else begin
      bit_cnt_reg <= load ? '0 : bit_cnt_reg + CNT_W'(1);
      if (load && state_reg == ST_INIT)
        init_cnt_reg <= init_cnt_reg + INIT_W'(1);
      if (load && state_reg == ST_RUN)
        lane_idx_reg <= (lane_idx_reg == LAST_LANE) ? '0 : lane_idx_reg + LSEL_W'(1);
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shift_reg    <= '0;
      idle_reg     <= 1'b0;
      lane_sel_reg <= '0;
      frame_reg    <= 1'b0;
    end else if (load) begin
      shift_reg    <= load_frame;
      idle_reg     <= !xfer;
      lane_sel_reg <= (state_reg == ST_RUN) ? lane_idx_reg : '0;
      frame_reg    <= (state_reg == ST_RUN) && (lane_idx_reg == '0);
    end else begin
      shift_reg    <= shift_reg << 1;
      frame_reg    <= 1'b0;
    end
  end

  assign data_out    = shift_reg[SLOT-1];
  assign IDLE_OUT    = idle_reg;
  assign lane_sel    = lane_sel_reg;
  assign frame_start = frame_reg;

endmodule
